// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
//============================================================================
// Module      : pipe_hazard_ctrl
// Description : Pipeline control unit for a Y86-64 five-stage pipeline.
//               It drives the stall and bubble controls of the F/D/E/M/W pipe
//               registers. It detects load/use hazards, ret hazards,
//               mispredicted jumps and exception/halt conditions.
//               After reset it forces a fixed-length flush, because the pipe
//               registers have no reset of their own. Once a non-AOK status
//               reaches writeback, it latches a terminal HALTED state.
//
//               Optional build macro PIPE_HAZARD_CTRL_PERF_EN:
//                 defined   -> four saturating performance counters exist
//                 undefined -> the counter ports are tied to 0
//
// Ports       : clk_i, rst_n_i      clock / async active-low reset
//               D_icode_i, d_srcA_i, d_srcB_i   decode-stage info
//               E_icode_i, E_dstM_i, e_Cnd_i    execute-stage info
//               M_icode_i, m_stat_i             memory-stage info
//               W_stat_i                        writeback status
//               F_stall_o .. W_stall_o          pipe register controls
//               halted_o, halt_stat_o           halt indication / status
//               cyc_cnt_o, lu_cnt_o, mp_cnt_o, ret_cnt_o   perf counters
// Revision    : 1.0 - initial release
//============================================================================
module pipe_hazard_ctrl #(
   parameter int FLUSH_CYCLES = 4,
   parameter int CNT_W        = 32
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic [3:0]       D_icode_i,
   input  logic [3:0]       d_srcA_i,
   input  logic [3:0]       d_srcB_i,
   input  logic [3:0]       E_icode_i,
   input  logic [3:0]       E_dstM_i,
   input  logic             e_Cnd_i,
   input  logic [3:0]       M_icode_i,
   input  logic [2:0]       m_stat_i,
   input  logic [2:0]       W_stat_i,
   output logic             F_stall_o,
   output logic             D_stall_o,
   output logic             D_bubble_o,
   output logic             E_bubble_o,
   output logic             M_bubble_o,
   output logic             W_stall_o,
   output logic             halted_o,
   output logic [2:0]       halt_stat_o,
   output logic [CNT_W-1:0] cyc_cnt_o,
   output logic [CNT_W-1:0] lu_cnt_o,
   output logic [CNT_W-1:0] mp_cnt_o,
   output logic [CNT_W-1:0] ret_cnt_o
);

   localparam logic [2:0] c_SAOK    = 3'h1;
   localparam logic [2:0] c_SADR    = 3'h2;
   localparam logic [2:0] c_SINS    = 3'h3;
   localparam logic [2:0] c_SHLT    = 3'h4;
   localparam logic [3:0] c_IMRMOVQ = 4'h5;
   localparam logic [3:0] c_IJXX    = 4'h7;
   localparam logic [3:0] c_IRET    = 4'h9;
   localparam logic [3:0] c_IPOPQ   = 4'hB;
   localparam logic [3:0] c_RNONE   = 4'hF;

   // The flush counter only needs to reach FLUSH_CYCLES-1.
   localparam int            c_FC_W       = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [c_FC_W-1:0] c_FLUSH_LAST = c_FC_W'(FLUSH_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_FLUSH  = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   state_t              r_state, w_state_nxt;
   logic [c_FC_W-1:0]   r_flush_cnt, w_flush_cnt_nxt;
   logic [2:0]          r_halt_stat, w_halt_stat_nxt;

   logic w_lu, w_rt, w_mp, w_rt_nolu, w_m_exc, w_w_exc;

   function automatic logic is_exc(input logic [2:0] stat);
      return (stat == c_SADR) || (stat == c_SINS) || (stat == c_SHLT);
   endfunction

   // Hazard detection, evaluated continuously and used only in RUN.
   always_comb begin
      w_lu      = ((E_icode_i == c_IMRMOVQ) || (E_icode_i == c_IPOPQ)) &&
                  (E_dstM_i != c_RNONE) &&
                  ((E_dstM_i == d_srcA_i) || (E_dstM_i == d_srcB_i));
      w_rt      = (D_icode_i == c_IRET) || (E_icode_i == c_IRET) || (M_icode_i == c_IRET);
      w_mp      = (E_icode_i == c_IJXX) && !e_Cnd_i;
      // A load/use stall holds the ret in D, so the ret bubble waits for it.
      w_rt_nolu = w_rt && !w_lu;
      w_m_exc   = is_exc(m_stat_i);
      w_w_exc   = is_exc(W_stat_i);
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state     <= ST_FLUSH;
         r_flush_cnt <= '0;
         r_halt_stat <= c_SAOK;
      end else begin
         r_state     <= w_state_nxt;
         r_flush_cnt <= w_flush_cnt_nxt;
         r_halt_stat <= w_halt_stat_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_flush_cnt_nxt = r_flush_cnt;
      w_halt_stat_nxt = r_halt_stat;
      F_stall_o       = 1'b1;
      D_stall_o       = 1'b0;
      D_bubble_o      = 1'b1;
      E_bubble_o      = 1'b1;
      M_bubble_o      = 1'b1;
      W_stall_o       = 1'b0;
      halted_o        = 1'b0;
      case (r_state)
         ST_FLUSH: begin
            if (r_flush_cnt == c_FLUSH_LAST) begin
               w_state_nxt     = ST_RUN;
               w_flush_cnt_nxt = '0;
            end else begin
               w_flush_cnt_nxt = r_flush_cnt + c_FC_W'(1);
            end
         end
         ST_RUN: begin
            F_stall_o  = w_lu || w_rt;
            D_stall_o  = w_lu;
            D_bubble_o = w_mp || w_rt_nolu;
            E_bubble_o = w_mp || w_lu;
            M_bubble_o = w_m_exc || w_w_exc;
            W_stall_o  = w_w_exc;
            if (w_w_exc) begin
               w_state_nxt     = ST_HALTED;
               w_halt_stat_nxt = W_stat_i;
            end
         end
         ST_HALTED: begin
            D_stall_o  = 1'b1;
            D_bubble_o = 1'b0;
            W_stall_o  = 1'b1;
            halted_o   = 1'b1;
         end
         default: begin
            w_state_nxt     = ST_FLUSH;
            w_flush_cnt_nxt = '0;
         end
      endcase
   end

   assign halt_stat_o = r_halt_stat;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
   logic             w_run;
   logic [CNT_W-1:0] r_cyc_cnt, r_lu_cnt, r_mp_cnt, r_ret_cnt;

   assign w_run = (r_state == ST_RUN);

   // Saturating counters, live only while the pipeline is running.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_cyc_cnt <= '0;
         r_lu_cnt  <= '0;
         r_mp_cnt  <= '0;
         r_ret_cnt <= '0;
      end else if (w_run) begin
         if (r_cyc_cnt != '1)              r_cyc_cnt <= r_cyc_cnt + CNT_W'(1);
         if (w_lu      && r_lu_cnt  != '1) r_lu_cnt  <= r_lu_cnt  + CNT_W'(1);
         if (w_mp      && r_mp_cnt  != '1) r_mp_cnt  <= r_mp_cnt  + CNT_W'(1);
         if (w_rt_nolu && r_ret_cnt != '1) r_ret_cnt <= r_ret_cnt + CNT_W'(1);
      end
   end

   assign cyc_cnt_o = r_cyc_cnt;
   assign lu_cnt_o  = r_lu_cnt;
   assign mp_cnt_o  = r_mp_cnt;
   assign ret_cnt_o = r_ret_cnt;
`else
   assign cyc_cnt_o = '0;
   assign lu_cnt_o  = '0;
   assign mp_cnt_o  = '0;
   assign ret_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
//============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Directed self-checking bench for pipe_hazard_ctrl, with
//               FLUSH_CYCLES=4 and CNT_W=4 so that counter saturation is
//               reachable. The counter expectations depend on
//               PIPE_HAZARD_CTRL_PERF_EN: when the macro is undefined,
//               every counter is expected to read 0.
// Revision    : 1.0 - initial release
//============================================================================
module tb_pipe_hazard_ctrl;

   localparam int CW   = 4;
   localparam int CMAX = 15;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   // Control vector order: {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, halted}
   localparam logic [6:0] V_RST  = 7'b1011100;
   localparam logic [6:0] V_HALT = 7'b1101111;
   localparam logic [6:0] V_NONE = 7'b0000000;
   localparam logic [6:0] V_LU   = 7'b1101000;
   localparam logic [6:0] V_RET  = 7'b1010000;
   localparam logic [6:0] V_MP   = 7'b0011000;
   localparam logic [6:0] V_MPRT = 7'b1011000;
   localparam logic [6:0] V_MEXC = 7'b0000100;
   localparam logic [6:0] V_WEXC = 7'b0000110;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [3:0]    D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode;
   logic          e_Cnd;
   logic [2:0]    m_stat, W_stat;
   logic          F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, halted;
   logic [2:0]    halt_stat;
   logic [CW-1:0] cyc_cnt, lu_cnt, mp_cnt, ret_cnt;

   int checks   = 0;
   int failures = 0;
   int exp_cyc, exp_lu, exp_mp, exp_ret;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(
      .FLUSH_CYCLES (4),
      .CNT_W        (CW)
   ) dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .D_icode_i   (D_icode),
      .d_srcA_i    (d_srcA),
      .d_srcB_i    (d_srcB),
      .E_icode_i   (E_icode),
      .E_dstM_i    (E_dstM),
      .e_Cnd_i     (e_Cnd),
      .M_icode_i   (M_icode),
      .m_stat_i    (m_stat),
      .W_stat_i    (W_stat),
      .F_stall_o   (F_stall),
      .D_stall_o   (D_stall),
      .D_bubble_o  (D_bubble),
      .E_bubble_o  (E_bubble),
      .M_bubble_o  (M_bubble),
      .W_stall_o   (W_stall),
      .halted_o    (halted),
      .halt_stat_o (halt_stat),
      .cyc_cnt_o   (cyc_cnt),
      .lu_cnt_o    (lu_cnt),
      .mp_cnt_o    (mp_cnt),
      .ret_cnt_o   (ret_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_ctrl(input string tag, input logic [6:0] expv);
      check(tag, {25'd0, F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, halted},
            {25'd0, expv});
   endtask

   task automatic check_cnts(input string tag);
      check({tag, "_cyc"}, {28'd0, cyc_cnt}, PERF ? exp_cyc : 0);
      check({tag, "_lu"},  {28'd0, lu_cnt},  PERF ? exp_lu  : 0);
      check({tag, "_mp"},  {28'd0, mp_cnt},  PERF ? exp_mp  : 0);
      check({tag, "_ret"}, {28'd0, ret_cnt}, PERF ? exp_ret : 0);
   endtask

   task automatic clr_model();
      exp_cyc = 0; exp_lu = 0; exp_mp = 0; exp_ret = 0;
   endtask

   // Put the current (already driven) inputs under test: check the controls,
   // clock once, advance the hand-given counter events and check counters.
   task automatic run_step(input string tag, input logic [6:0] ctrl, input bit cnt_en,
                           input bit lu, input bit mp, input bit rn);
      check_ctrl(tag, ctrl);
      tick();
      if (cnt_en) begin
         if (exp_cyc < CMAX)       exp_cyc++;
         if (lu && exp_lu < CMAX)  exp_lu++;
         if (mp && exp_mp < CMAX)  exp_mp++;
         if (rn && exp_ret < CMAX) exp_ret++;
      end
      check_cnts(tag);
   endtask

   task automatic neutral();
      D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1;
      d_srcA  = 4'hF; d_srcB  = 4'hF; E_dstM  = 4'hF;
      e_Cnd   = 1'b0; m_stat  = 3'h1; W_stat  = 3'h1;
   endtask

   initial begin
      clr_model();
      neutral();
      rst_n  = 1'b0;
      W_stat = 3'h3;                  // SINS held through reset and flush
      tick(); tick();
      check_ctrl("rst_ctrl", V_RST);
      check("rst_hstat", {29'd0, halt_stat}, 32'd1);
      check_cnts("rst");

      // Flush lasts exactly 4 cycles and ignores the SINS status.
      rst_n = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) begin
         check_ctrl($sformatf("flush%0d_ctrl", i), V_RST);
         tick();
      end
      check_ctrl("run_sins", V_WEXC);
      tick();
      exp_cyc = 1;
      check_ctrl("halt_sins", V_HALT);
      check("halt_sins_stat", {29'd0, halt_stat}, 32'd3);
      check_cnts("halt_sins");

      // Asynchronous reset from HALTED.
      rst_n = 1'b0;
      #1;
      clr_model();
      check_ctrl("areset_ctrl", V_RST);
      check("areset_hstat", {29'd0, halt_stat}, 32'd1);
      check_cnts("areset");
      neutral();
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) run_step($sformatf("flush2_%0d", i), V_RST, 1'b0, 1'b0, 1'b0, 1'b0);

      run_step("idle", V_NONE, 1'b1, 1'b0, 1'b0, 1'b0);

      E_icode = 4'h5; E_dstM = 4'h3; d_srcB = 4'h3; #1;
      run_step("lu_mrmov", V_LU, 1'b1, 1'b1, 1'b0, 1'b0);

      E_dstM = 4'hF; d_srcA = 4'hF; d_srcB = 4'hF; #1;
      run_step("lu_rnone", V_NONE, 1'b1, 1'b0, 1'b0, 1'b0);

      neutral(); D_icode = 4'h9; E_icode = 4'hB; E_dstM = 4'h4; d_srcA = 4'h4; #1;
      run_step("ret_lu", V_LU, 1'b1, 1'b1, 1'b0, 1'b0);

      E_icode = 4'h1; #1;
      run_step("ret_after_lu", V_RET, 1'b1, 1'b0, 1'b0, 1'b1);

      neutral(); M_icode = 4'h9; #1;
      run_step("ret_in_m", V_RET, 1'b1, 1'b0, 1'b0, 1'b1);

      neutral(); E_icode = 4'h7; e_Cnd = 1'b0; #1;
      run_step("mispredict", V_MP, 1'b1, 1'b0, 1'b1, 1'b0);

      e_Cnd = 1'b1; #1;
      run_step("jxx_taken", V_NONE, 1'b1, 1'b0, 1'b0, 1'b0);

      e_Cnd = 1'b0; D_icode = 4'h9; #1;
      run_step("mp_and_ret", V_MPRT, 1'b1, 1'b0, 1'b1, 1'b1);

      neutral(); m_stat = 3'h2; #1;
      run_step("m_sadr", V_MEXC, 1'b1, 1'b0, 1'b0, 1'b0);

      neutral(); W_stat = 3'h0; #1;
      run_step("w_stat0", V_NONE, 1'b1, 1'b0, 1'b0, 1'b0);
      W_stat = 3'h5; #1;
      run_step("w_stat5", V_NONE, 1'b1, 1'b0, 1'b0, 1'b0);
      W_stat = 3'h7; #1;
      run_step("w_stat7", V_NONE, 1'b1, 1'b0, 1'b0, 1'b0);

      neutral(); #1;
      for (int i = 0; i < 20; i++) run_step($sformatf("sat%0d", i), V_NONE, 1'b1, 1'b0, 1'b0, 1'b0);
      check("sat_cyc", {28'd0, cyc_cnt}, PERF ? 32'd15 : 32'd0);

      W_stat = 3'h4; #1;
      run_step("halt_pre", V_WEXC, 1'b1, 1'b0, 1'b0, 1'b0);
      check_ctrl("halted_ctrl", V_HALT);
      check("halted_stat", {29'd0, halt_stat}, 32'd4);

      // HALTED ignores every input, including a return to AOK.
      W_stat = 3'h1; E_icode = 4'h5; E_dstM = 4'h2; d_srcA = 4'h2; D_icode = 4'h9; #1;
      run_step("halted_hold0", V_HALT, 1'b0, 1'b0, 1'b0, 1'b0);
      E_icode = 4'h7; #1;
      run_step("halted_hold1", V_HALT, 1'b0, 1'b0, 1'b0, 1'b0);
      check("halted_stat_hold", {29'd0, halt_stat}, 32'd4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
